// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter slice.
//   - arb_state_e : access sequencer states (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - req_id_e    : requester identifiers used for arbitration and the grant register
//   - MEM_LAT_MIN / MEM_LAT_MAX : legal memory read latency range
//   - lat_clamp() : folds a latency parameter into the legal range for the counter load
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_HS   = 2'd3
  } req_id_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  typedef logic [2:0] lat_cnt_t;

  // An out-of-range latency would make the WAIT count meaningless, so it is
  // pinned to the nearest legal value instead.
  function automatic lat_cnt_t lat_clamp(input int lat);
    if (lat < MEM_LAT_MIN) begin
      return lat_cnt_t'(MEM_LAT_MIN);
    end else if (lat > MEM_LAT_MAX) begin
      return lat_cnt_t'(MEM_LAT_MAX);
    end else begin
      return lat_cnt_t'(lat);
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the three requester ports, the core_halted flag,
// the shared read-data/busy outputs and the memory macro port.
//   slave  : arbiter side (samples requests and mem_rdata, drives acks and mem_*)
//   master : pipeline/host/memory side (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              core_halted;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic              hs_req;
  logic              hs_we;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_wdata;
  logic              hs_ack;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  core_halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           hs_req, hs_we, hs_addr, hs_wdata, mem_rdata,
    output if_ack, dm_ack, hs_ack, rd_data, mem_en, mem_we, mem_addr,
           mem_wdata, busy
  );

  modport master (
    output core_halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           hs_req, hs_we, hs_addr, hs_wdata, mem_rdata,
    input  if_ack, dm_ack, hs_ack, rd_data, mem_en, mem_we, mem_addr,
           mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// mem_arb_prio: combinational priority picker.
//   in : if_req, dm_req, hs_req, core_halted, starve (fetch has waited too long)
//   out: winner (req_id_e, REQ_NONE when nothing is eligible)
// Order: halted host, starved fetch, data, fetch.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    dm_req,
  input  logic    hs_req,
  input  logic    core_halted,
  input  logic    starve,
  output req_id_e winner
);

  // Fixed-priority selection of one requester.
  always_comb begin
    winner = REQ_NONE;
    if (hs_req && core_halted) begin
      winner = REQ_HS;
    end else if (if_req && starve) begin
      winner = REQ_IF;
    end else if (dm_req) begin
      winner = REQ_DM;
    end else if (if_req) begin
      winner = REQ_IF;
    end else begin
      winner = REQ_NONE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory among fetch (IF),
// data (DM) and host loader (HS) through an IDLE/ISSUE/WAIT/RESP sequencer.
//   clk1, reset : clock and synchronous active-high reset
//   bus (slave) : requester handshakes, core_halted, rd_data, busy and memory port
// All outputs are registered. A grant in IDLE (cycle 0) puts mem_en out in
// cycle 1 and the ack in cycle MEM_LAT+2.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 3
) (
  input logic               clk1,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam lat_cnt_t LAT_LOAD = lat_clamp(MEM_LAT);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

  arb_state_e        state_r;
  req_id_e           grant_r;
  logic [SC_W-1:0]   starve_cnt_r;
  lat_cnt_t          lat_cnt_r;
  logic              req_we_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              if_ack_r;
  logic              dm_ack_r;
  logic              hs_ack_r;
  logic              busy_r;

  req_id_e           winner_s;
  logic              starve_flag_s;
  logic [SC_W-1:0]   starve_nxt_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  assign starve_flag_s = (starve_cnt_r == STARVE_MAX);

  mem_arb_prio u_prio (
    .if_req      (bus.if_req),
    .dm_req      (bus.dm_req),
    .hs_req      (bus.hs_req),
    .core_halted (bus.core_halted),
    .starve      (starve_flag_s),
    .winner      (winner_s)
  );

  // Route the winning requester's command fields; fetches are always reads.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = {ADDR_W{1'b0}};
    win_wdata_s = {DATA_W{1'b0}};
    case (winner_s)
      REQ_IF: begin
        win_addr_s = bus.if_addr;
      end
      REQ_DM: begin
        win_we_s    = bus.dm_we;
        win_addr_s  = bus.dm_addr;
        win_wdata_s = bus.dm_wdata;
      end
      REQ_HS: begin
        win_we_s    = bus.hs_we;
        win_addr_s  = bus.hs_addr;
        win_wdata_s = bus.hs_wdata;
      end
      default: begin
        win_we_s = 1'b0;
      end
    endcase
  end

  // Starvation count: a DM win over a waiting fetch adds one (saturating);
  // a fetch win or an idle fetch line clears it; a host win leaves it alone.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (!bus.if_req || (winner_s == REQ_IF)) begin
      starve_nxt_s = {SC_W{1'b0}};
    end else if ((winner_s == REQ_DM) && !starve_flag_s) begin
      starve_nxt_s = starve_cnt_r + SC_W'(1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Access sequencer with registered memory strobe, read data, acks and busy.
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_r      <= IDLE;
      grant_r      <= REQ_NONE;
      starve_cnt_r <= {SC_W{1'b0}};
      lat_cnt_r    <= 3'd0;
      req_we_r     <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      rd_data_r    <= {DATA_W{1'b0}};
      if_ack_r     <= 1'b0;
      dm_ack_r     <= 1'b0;
      hs_ack_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          starve_cnt_r <= starve_nxt_s;
          if (winner_s != REQ_NONE) begin
            // The memory command registers double as the latched request.
            grant_r     <= winner_s;
            req_we_r    <= win_we_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= win_we_s;
            mem_addr_r  <= win_addr_s;
            mem_wdata_r <= win_wdata_s;
            busy_r      <= 1'b1;
            state_r     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_addr_r  <= {ADDR_W{1'b0}};
          mem_wdata_r <= {DATA_W{1'b0}};
          lat_cnt_r   <= LAT_LOAD;
          state_r     <= WAIT;
        end
        WAIT: begin
          if (lat_cnt_r <= 3'd1) begin
            // Read data is due this cycle; writes return zero.
            lat_cnt_r <= 3'd0;
            rd_data_r <= req_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
            if_ack_r  <= (grant_r == REQ_IF);
            dm_ack_r  <= (grant_r == REQ_DM);
            hs_ack_r  <= (grant_r == REQ_HS);
            state_r   <= RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        RESP: begin
          rd_data_r <= {DATA_W{1'b0}};
          if_ack_r  <= 1'b0;
          dm_ack_r  <= 1'b0;
          hs_ack_r  <= 1'b0;
          grant_r   <= REQ_NONE;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.if_ack    = if_ack_r;
  assign bus.dm_ack    = dm_ack_r;
  assign bus.hs_ack    = hs_ack_r;
  assign bus.busy      = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word memory (program and data) among three requesters: instruction fetch (IF), data access (DM, the MEM stage) and a host loader (HS).
- HS preloads the program and inspects memory while the core is halted.
- Sits between the mips pipeline and the memory macro, replacing direct Mem array access.
- Sequences each access through a fixed-latency FSM and prevents fetch starvation.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).
- STARVE_LIM, 3, consecutive DM wins over a waiting IF before IF is forced.

Ports:
- clk1  in  1  single clock. Synchronous, active-high reset; all state changes on the rising edge of clk1.
- reset  in  1  synchronous, active-high reset.
- core_halted  in  1  core HALTED flag; HS is eligible only while this is 1.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse; rd_data valid.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle completion pulse.
- hs_req  in  1  host request, held until hs_ack.
- hs_we  in  1  host write enable.
- hs_addr  in  ADDR_W  host address.
- hs_wdata  in  DATA_W  host write data.
- hs_ack  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  read data, valid only in an ack cycle.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  FSM not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, FSM=IDLE, starvation counter=0, grant register=none.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate on the sampled requests. If any is eligible, latch the winner's id, addr, we and wdata, and go to ISSUE.
- Priority order:
  1. HS, if hs_req and core_halted.
  2. IF, if if_req and starve_cnt==STARVE_LIM.
  3. DM.
  4. IF.
- starve_cnt:
  - increments when DM wins while if_req=1;
  - clears when IF wins or if_req=0;
  - saturates at STARVE_LIM.
- ISSUE: mem_en=1 for exactly one cycle, with mem_we/mem_addr/mem_wdata from the latched request. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture mem_rdata (reads) or 0 (writes) into rd_data and go to RESP.
- RESP: pulse the winner's ack for one cycle with rd_data valid, then go to IDLE. rd_data returns to 0 the next cycle.
- Timing: request sampled in IDLE at cycle 0 → mem_en in cycle 1 → ack in cycle MEM_LAT+2. One access per MEM_LAT+3 cycles at most.
- Requesters must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- Simultaneous requests: exactly one is granted per IDLE cycle; losers keep req asserted and wait.
- core_halted falling during an HS access: the access completes; HS becomes ineligible from the next IDLE.
- hs_req while core_halted=0: ignored, and HS never acks.
- Request inputs are only sampled in IDLE; changes during ISSUE/WAIT/RESP have no effect.
- Reset mid-access: return to IDLE, suppress the pending ack, ignore the late mem_rdata, clear starve_cnt.
- Writes ignore mem_rdata.

Decomposition:
- Shared package mem_arb_pkg:
  - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - requester id constants (REQ_NONE, REQ_IF, REQ_DM, REQ_HS);
  - MEM_LAT legal-range constants.
- One natural sub-module: mem_arb_prio, a combinational priority picker taking the three reqs, core_halted and the starve flag and returning a winner id.
- The FSM, counters and datapath registers stay in mem_port_arbiter.

Test Plan (all with MEM_LAT=1, STARVE_LIM=3):
- Reset then core_halted=1, HS writes 32'h2801000a to address 0 → mem_en/mem_we in cycle 1, hs_ack in cycle 3. HS read of address 0 → rd_data=32'h2801000a with hs_ack.
- if_req and dm_req (load, address 5, memory holds 32'h00222000) both asserted in the same cycle → dm_ack first with rd_data=32'h00222000. if_ack follows 4 cycles later.
- dm_req held continuously with if_req pending → DM wins 3 times, the 4th grant goes to IF, then starve_cnt resets to 0.
- hs_req with core_halted=0 alongside if_req → only IF is served. hs_ack stays 0 until core_halted=1, then HS outranks a concurrent dm_req.
- Reset asserted in the WAIT cycle of a DM load → no dm_ack, all outputs 0, busy=0 on the next cycle. A re-asserted request is served normally afterwards.
- DM store of 32'hfc000000 to address 8, then IF fetch of address 8 → if_ack with rd_data=32'hfc000000. rd_data=0 in the store's ack cycle.
